// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// It drives the PC and pipeline-register enables and flushes, and the
// PC-source selects. It handles four situations:
//   - load-use hazards, by inserting a one-cycle bubble;
//   - taken branches resolved in MEM, by squashing the three younger stages;
//   - jumps decoded in ID, by squashing the fetched instruction;
//   - data memory not ready, by freezing the whole pipe.
// Every other RAW hazard is left to ForwardUnit.
//
// Optional feature: define HAZARD_STATS_EN to build the saturating
// stall/flush statistics counters. Without it both counter ports read 0.
//
// Parameters:
//   N           register-address width
//   MAX_WAIT    memory-wait cycles before mem_timeout_o sets (1..255)
//   STAT_WIDTH  width of the statistics counters
//
// Ports:
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset
//   id_rs_i/id_rt_i  source register fields of the instruction in ID
//   id_uses_rt_i     ID instruction reads rt as a source
//   id_jump_i        ID instruction is j/jal
//   ex_mem_read_i    instruction in EX is a load
//   ex_rt_i          destination register of that load
//   mem_access_i     instruction in MEM is a load or store
//   mem_ready_i      data memory completes the access this cycle
//   branch_taken_i   branch in MEM is taken
//   pc_enable_o, if_id_enable_o, id_ex_enable_o, ex_mem_enable_o
//                    register load enables
//   if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o
//                    load a NOP into the pipeline register
//   pc_sel_branch_o  PC takes the branch target
//   pc_sel_jump_o    PC takes the jump target
//   mem_timeout_o    sticky memory watchdog flag
//   stall_count_o    load-use and memory-wait stall cycles
//   flush_count_o    branch and jump flush events
// ---------------------------------------------------------------------------
module hazard_controller #(
    parameter int N          = 5,
    parameter int MAX_WAIT   = 15,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [N-1:0]          id_rs_i,
    input  logic [N-1:0]          id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_jump_i,
    input  logic                  ex_mem_read_i,
    input  logic [N-1:0]          ex_rt_i,
    input  logic                  mem_access_i,
    input  logic                  mem_ready_i,
    input  logic                  branch_taken_i,
    output logic                  pc_enable_o,
    output logic                  if_id_enable_o,
    output logic                  id_ex_enable_o,
    output logic                  ex_mem_enable_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic                  mem_wb_flush_o,
    output logic                  pc_sel_branch_o,
    output logic                  pc_sel_jump_o,
    output logic                  mem_timeout_o,
    output logic [STAT_WIDTH-1:0] stall_count_o,
    output logic [STAT_WIDTH-1:0] flush_count_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic       timeout_q, timeout_d;

    logic loadUse;
    logic memWait;

    // Hazard detection. Register $zero is never a real dependency, so a
    // load targeting it must not stall.
    assign loadUse = ex_mem_read_i && (ex_rt_i != '0) &&
                     ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    assign memWait = mem_access_i && !mem_ready_i;

    // The timeout flag is hidden while reset is held so the error line
    // reads clean during the reset cycle itself.
    assign mem_timeout_o = timeout_q && !reset_i;

    // Mealy output and next-state logic. Outputs depend on the current
    // inputs so stalls and flushes act on the very next clock edge.
    // RUN and STALL share the priority chain; STALL only differs in that
    // it never chains into a second STALL. In WAIT the pipe stays frozen
    // until memory answers, and the release cycle is deliberately plain
    // idle so the completed access can move into MEM/WB.
    always_comb begin
        pc_enable_o     = 1'b1;
        if_id_enable_o  = 1'b1;
        id_ex_enable_o  = 1'b1;
        ex_mem_enable_o = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_flush_o  = 1'b0;
        mem_wb_flush_o  = 1'b0;
        pc_sel_branch_o = 1'b0;
        pc_sel_jump_o   = 1'b0;
        state_d         = state_q;
        waitCnt_d       = waitCnt_q;
        timeout_d       = timeout_q;

        if (!reset_i) begin
            case (state_q)
                RUN, STALL: begin
                    state_d = RUN;
                    if (memWait) begin
                        pc_enable_o     = 1'b0;
                        if_id_enable_o  = 1'b0;
                        id_ex_enable_o  = 1'b0;
                        ex_mem_enable_o = 1'b0;
                        mem_wb_flush_o  = 1'b1;
                        state_d         = WAIT;
                        waitCnt_d       = 8'd0;
                    end else if (branch_taken_i) begin
                        pc_sel_branch_o = 1'b1;
                        if_id_flush_o   = 1'b1;
                        id_ex_flush_o   = 1'b1;
                        ex_mem_flush_o  = 1'b1;
                    end else if (loadUse) begin
                        pc_enable_o    = 1'b0;
                        if_id_enable_o = 1'b0;
                        id_ex_flush_o  = 1'b1;
                        if (state_q == RUN) begin
                            state_d = STALL;
                        end
                    end else if (id_jump_i) begin
                        pc_sel_jump_o = 1'b1;
                        if_id_flush_o = 1'b1;
                    end
                end
                WAIT: begin
                    if (!mem_ready_i) begin
                        pc_enable_o     = 1'b0;
                        if_id_enable_o  = 1'b0;
                        id_ex_enable_o  = 1'b0;
                        ex_mem_enable_o = 1'b0;
                        mem_wb_flush_o  = 1'b1;
                        if (waitCnt_q != 8'hFF) begin
                            waitCnt_d = waitCnt_q + 8'd1;
                        end
                        if (waitCnt_d == MaxWaitC) begin
                            timeout_d = 1'b1;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Control state, watchdog counter and the sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= RUN;
            waitCnt_q <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic                  stallInc;
    logic                  flushInc;
    logic [STAT_WIDTH-1:0] stallCnt_q;
    logic [STAT_WIDTH-1:0] flushCnt_q;

    // A stall cycle is the bubble cycle spent in STALL or any cycle the
    // pipe is frozen on memory, including the cycle that enters WAIT.
    // Flush events are the branch and jump decisions taken outside WAIT.
    always_comb begin
        stallInc = !reset_i &&
                   ((state_q == STALL) ||
                    ((state_q != WAIT) && memWait) ||
                    ((state_q == WAIT) && !mem_ready_i));
        flushInc = !reset_i && (state_q != WAIT) && !memWait &&
                   (branch_taken_i || (!loadUse && id_jump_i));
    end

    // Saturating statistics counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (stallInc && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + 1'b1;
            end
            if (flushInc && (flushCnt_q != '1)) begin
                flushCnt_q <= flushCnt_q + 1'b1;
            end
        end
    end

    assign stall_count_o = stallCnt_q;
    assign flush_count_o = flushCnt_q;
`else
    assign stall_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//
// Self-checking bench for hazard_controller. A behavioural model tracks
// whether the pipe is waiting on memory, whether a bubble was just inserted,
// the watchdog count and the statistics, and predicts the control outputs
// each cycle. Directed scenarios come first, then randomised traffic with
// occasional reset pulses. The DUT is built with MAX_WAIT=4 so the watchdog
// is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

    localparam int N        = 5;
    localparam int MAX_WAIT = 4;
    localparam int SW       = 16;
    localparam int STAT_MAX = (1 << SW) - 1;

    // Output vector order: pcEn, ifIdEn, idExEn, exMemEn,
    // ifIdFl, idExFl, exMemFl, memWbFl, selBranch, selJump
    localparam logic [9:0] OUT_IDLE   = 10'b1111_0000_00;
    localparam logic [9:0] OUT_FREEZE = 10'b0000_0001_00;
    localparam logic [9:0] OUT_BRANCH = 10'b1111_1110_10;
    localparam logic [9:0] OUT_LDUSE  = 10'b0011_0100_00;
    localparam logic [9:0] OUT_JUMP   = 10'b1111_1000_01;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  idRs = '0;
    logic [N-1:0]  idRt = '0;
    logic          idUsesRt = 1'b0;
    logic          idJump = 1'b0;
    logic          exMemRead = 1'b0;
    logic [N-1:0]  exRt = '0;
    logic          memAccess = 1'b0;
    logic          memReady = 1'b1;
    logic          branchTaken = 1'b0;

    logic          pcEnable, ifIdEnable, idExEnable, exMemEnable;
    logic          ifIdFlush, idExFlush, exMemFlush, memWbFlush;
    logic          pcSelBranch, pcSelJump, memTimeout;
    logic [SW-1:0] stallCount, flushCount;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit mKnown     = 1'b0;
    bit mWaiting   = 1'b0;
    bit mBubble    = 1'b0;
    int mWaitCnt   = 0;
    bit mTimeout   = 1'b0;
    int mStallCnt  = 0;
    int mFlushCnt  = 0;

    always #5 clk = ~clk;

    hazard_controller #(
        .N(N),
        .MAX_WAIT(MAX_WAIT),
        .STAT_WIDTH(SW)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .id_rs_i(idRs),
        .id_rt_i(idRt),
        .id_uses_rt_i(idUsesRt),
        .id_jump_i(idJump),
        .ex_mem_read_i(exMemRead),
        .ex_rt_i(exRt),
        .mem_access_i(memAccess),
        .mem_ready_i(memReady),
        .branch_taken_i(branchTaken),
        .pc_enable_o(pcEnable),
        .if_id_enable_o(ifIdEnable),
        .id_ex_enable_o(idExEnable),
        .ex_mem_enable_o(exMemEnable),
        .if_id_flush_o(ifIdFlush),
        .id_ex_flush_o(idExFlush),
        .ex_mem_flush_o(exMemFlush),
        .mem_wb_flush_o(memWbFlush),
        .pc_sel_branch_o(pcSelBranch),
        .pc_sel_jump_o(pcSelJump),
        .mem_timeout_o(memTimeout),
        .stall_count_o(stallCount),
        .flush_count_o(flushCount)
    );

    // Predict this cycle's outputs from the current inputs and advance
    // the model by one clock.
    task automatic modelStep(output logic [9:0] expOut, output logic expTimeout);
        bit loadUse, memWait, wasBubble;
        expTimeout = mTimeout && !reset;
        if (reset) begin
            expOut    = OUT_IDLE;
            mKnown    = 1'b1;
            mWaiting  = 1'b0;
            mBubble   = 1'b0;
            mWaitCnt  = 0;
            mTimeout  = 1'b0;
            mStallCnt = 0;
            mFlushCnt = 0;
            return;
        end
        loadUse = exMemRead && (exRt != 0) &&
                  ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
        memWait = memAccess && !memReady;
        if (mWaiting) begin
            if (!memReady) begin
                expOut = OUT_FREEZE;
                if (mStallCnt < STAT_MAX) mStallCnt++;
                if (mWaitCnt < 255) mWaitCnt++;
                if (mWaitCnt == MAX_WAIT) mTimeout = 1'b1;
            end else begin
                expOut   = OUT_IDLE;
                mWaiting = 1'b0;
            end
        end else begin
            wasBubble = mBubble;
            mBubble   = 1'b0;
            if (wasBubble || memWait) begin
                if (mStallCnt < STAT_MAX) mStallCnt++;
            end
            if (memWait) begin
                expOut   = OUT_FREEZE;
                mWaiting = 1'b1;
                mWaitCnt = 0;
            end else if (branchTaken) begin
                expOut = OUT_BRANCH;
                if (mFlushCnt < STAT_MAX) mFlushCnt++;
            end else if (loadUse) begin
                expOut  = OUT_LDUSE;
                mBubble = !wasBubble;
            end else if (idJump) begin
                expOut = OUT_JUMP;
                if (mFlushCnt < STAT_MAX) mFlushCnt++;
            end else begin
                expOut = OUT_IDLE;
            end
        end
    endtask

    // Compare the DUT against the model. Counters are compared before the
    // model advances, since they reflect only edges already taken.
    task automatic checkOutput(input string tag);
        logic [9:0]    obsOut, expOut;
        logic          expTimeout;
        logic [SW-1:0] expStall, expFlush;
`ifdef HAZARD_STATS_EN
        expStall = SW'(mStallCnt);
        expFlush = SW'(mFlushCnt);
`else
        expStall = '0;
        expFlush = '0;
`endif
        if (mKnown) begin
            checks++;
            assert (stallCount === expStall) else begin
                errors++;
                $error("[TB] FAIL %s stall_count: observed %0d expected %0d", tag, stallCount, expStall);
            end
            checks++;
            assert (flushCount === expFlush) else begin
                errors++;
                $error("[TB] FAIL %s flush_count: observed %0d expected %0d", tag, flushCount, expFlush);
            end
        end
        modelStep(expOut, expTimeout);
        obsOut = {pcEnable, ifIdEnable, idExEnable, exMemEnable,
                  ifIdFlush, idExFlush, exMemFlush, memWbFlush,
                  pcSelBranch, pcSelJump};
        checks++;
        assert (obsOut === expOut) else begin
            errors++;
            $error("[TB] FAIL %s controls: observed %b expected %b", tag, obsOut, expOut);
        end
        checks++;
        assert (memTimeout === expTimeout) else begin
            errors++;
            $error("[TB] FAIL %s mem_timeout: observed %b expected %b", tag, memTimeout, expTimeout);
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, then let the
    // rising edge commit.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [N-1:0] rs, input logic [N-1:0] rt,
                                 input logic usesRt, input logic jump,
                                 input logic memRd, input logic [N-1:0] loadRt,
                                 input logic access, input logic ready,
                                 input logic branch);
        reset       = rst;
        idRs        = rs;
        idRt        = rt;
        idUsesRt    = usesRt;
        idJump      = jump;
        exMemRead   = memRd;
        exRt        = loadRt;
        memAccess   = access;
        memReady    = ready;
        branchTaken = branch;
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // Reset
        applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus("idle",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Load-use on rs: one bubble, then idle
        applyStimulus("lduse",      0, 8, 3, 0, 0, 1, 8, 0, 1, 0);
        applyStimulus("lduseAfter", 0, 8, 3, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus("lduseIdle",  0, 1, 2, 0, 0, 0, 0, 0, 1, 0);

        // Load-use on rt only counts when rt is a source
        applyStimulus("rtUnused", 0, 1, 9, 0, 0, 1, 9, 0, 1, 0);
        applyStimulus("rtUsed",   0, 1, 9, 1, 0, 1, 9, 0, 1, 0);
        applyStimulus("rtAfter",  0, 1, 9, 1, 0, 0, 0, 0, 1, 0);

        // Load to $zero never stalls
        applyStimulus("zeroRt", 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);

        // Branch beats load-use and jump
        applyStimulus("brLduse", 0, 8, 0, 0, 1, 1, 8, 0, 1, 1);
        applyStimulus("brAfter", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Jump with load-use: stall first, jump once the bubble is in
        applyStimulus("jmpLduse", 0, 7, 0, 0, 1, 1, 7, 0, 1, 0);
        applyStimulus("jmpLater", 0, 7, 0, 0, 1, 0, 0, 0, 1, 0);
        applyStimulus("jmpIdle",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Memory not ready for 3 cycles, released on the 4th
        for (int i = 0; i < 3; i++)
            applyStimulus("memWait3", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("memRel3", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("postRel", 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);

        // Watchdog: mem_ready low for 10 cycles, flag sticks afterwards
        for (int i = 0; i < 10; i++)
            applyStimulus("memWait10", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("memRel10", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("tmoSticky", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus("tmoSticky", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

        // Reset pulsed mid-WAIT
        applyStimulus("rstWait0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("rstWait1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("rstInWait", 1, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        applyStimulus("afterRst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset pulsed in STALL
        applyStimulus("rstStall0", 0, 4, 0, 0, 0, 1, 4, 0, 1, 0);
        applyStimulus("rstInStall", 1, 4, 0, 0, 0, 1, 4, 0, 1, 0);
        applyStimulus("afterRstSt", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus("random",
                          ($urandom_range(0, 79) == 0),
                          N'($urandom_range(0, 3)),
                          N'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) < 2),
                          N'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 6) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It drives the enable and flush inputs of the four `Pipeline` registers and the PC register, and the PC-source selects. It resolves load-use hazards with a one-cycle bubble, squashes wrong-path instructions on taken branches (resolved in MEM) and jumps (decoded in ID), and freezes the whole pipe while data memory is not ready. It works alongside `ForwardUnit`: forwarding covers every RAW case except load-use.

## Interface
Parameters:
- N, 5, register-address width
- MAX_WAIT, 15, WAIT cycles before `mem_timeout` sets; legal range 1..255
- STAT_WIDTH, 16, width of the statistics counters

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  N  rs field of the IF/ID instruction
- id_rt  in  N  rt field of the IF/ID instruction
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_jump  in  1  ID instruction is j or jal
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_rt  in  N  destination (rt) of the ID/EX load
- mem_access  in  1  EX/MEM instruction is a load or store
- mem_ready  in  1  data memory completes the access this cycle
- branch_taken  in  1  EX/MEM branch condition true
- pc_enable  out  1  PC register load enable
- if_id_enable  out  1  IF/ID enable
- id_ex_enable  out  1  ID/EX enable
- ex_mem_enable  out  1  EX/MEM enable
- if_id_flush  out  1  load zeros (NOP) into IF/ID
- id_ex_flush  out  1  load zeros into ID/EX
- ex_mem_flush  out  1  load zeros into EX/MEM
- mem_wb_flush  out  1  load zeros into MEM/WB
- pc_sel_branch  out  1  PC takes the branch target
- pc_sel_jump  out  1  PC takes the jump target
- mem_timeout  out  1  sticky error flag
- stall_count  out  STAT_WIDTH  load-use and WAIT stall cycles
- flush_count  out  STAT_WIDTH  branch and jump flush events

## Operation
- FSM states: RUN, STALL, WAIT. Reset state: RUN.
- Idle outputs: all enables 1, all flushes 0, both selects 0.
- load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- mem_wait = mem_access & ~mem_ready.
- RUN priority (highest first):
  1. mem_wait: all enables 0, mem_wb_flush=1; go to WAIT.
  2. branch_taken: pc_sel_branch=1; if_id_flush, id_ex_flush, ex_mem_flush = 1; stay in RUN.
  3. load_use: pc_enable=0, if_id_enable=0, id_ex_flush=1; go to STALL.
  4. id_jump: pc_sel_jump=1, if_id_flush=1; stay in RUN.
  5. Otherwise idle outputs; stay in RUN.
- STALL: lasts exactly one cycle; re-evaluate all RUN rules (the bubble now sits in EX); go to RUN unless rule 1 applies, in which case go to WAIT.
- WAIT:
  - While mem_ready=0: all enables 0, mem_wb_flush=1.
  - Cycle with mem_ready=1: idle outputs so the result moves into MEM/WB; go to RUN. Rules 2–4 are not evaluated in that cycle.
- Watchdog: wait_cnt (8 bits) clears on entering WAIT and increments each cycle in WAIT with mem_ready=0. When it equals MAX_WAIT, mem_timeout sets and stays set until reset. The FSM stays in WAIT regardless.
- Simultaneous events:
  - id_jump together with load_use: the stall wins; the jump is taken once the stall clears.
  - branch_taken together with load_use or id_jump: the branch wins and both younger instructions are flushed.
- ex_rt == 0 never stalls.

## Timing
- All outputs are combinational (Mealy) from the current state and inputs, so they act on the same clock edge. State, wait_cnt, mem_timeout and the counters are registered.
- While reset=1: outputs forced to idle values, mem_timeout=0. On the edge with reset=1: state←RUN, wait_cnt←0, counters←0.
- Reset asserted in WAIT or STALL: outputs are idle in that same cycle; RUN from the next cycle.
- Load-use penalty: 1 cycle. Taken-branch penalty: 3 instructions flushed. Jump penalty: 1 instruction flushed.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments on each cycle in STALL and each WAIT cycle with mem_ready=0.
  - flush_count increments on each rule-2 or rule-4 event.
  - Both saturate at all-ones.
- HAZARD_STATS_EN undefined: no counter registers are built; stall_count and flush_count are tied to 0.

## Test plan
- `lw $t0` in ID/EX (ex_rt=8), `add` in ID with id_rs=8 → one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1; next cycle idle in RUN; stall_count=1.
- ex_mem_read=1, ex_rt=0, id_rs=0 → no stall, idle outputs.
- branch_taken=1 together with load_use=1 → pc_sel_branch=1, three flushes, pc_enable=1; flush_count=1; state stays RUN.
- mem_access=1 with mem_ready low for 3 cycles → 3 frozen cycles with mem_wb_flush=1, release on the 4th; stall_count=3; mem_timeout=0.
- MAX_WAIT=4, mem_ready held low for 10 cycles → mem_timeout rises on the 5th WAIT cycle, stays 1 after mem_ready; cleared only by reset=1.
- reset pulsed mid-WAIT → idle outputs in the reset cycle; state RUN and counters 0 afterwards.
